// File: rtl/coproc_host_driver.sv
// Host-side initiator for the crypto coprocessor register interface: takes one
// job per command handshake, runs the write/start/poll/read sequence and returns
// the 128-bit result (or a timeout flag) on the response channel.
module coproc_host_driver #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  input  logic [127:0] cmd_data,
  input  logic [127:0] cmd_iv,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [127:0] resp_data,
  output logic         resp_timeout,
  output logic         busy,
  output logic [15:0]  writeEnable,
  output logic [255:0] writeBus,
  output logic [3:0]   selectRead,
  input  logic [255:0] dataOut
);

  localparam int unsigned DATA_W = 128;
  localparam int unsigned BUS_W  = 256;
  localparam int unsigned WE_W   = 16;
  localparam int unsigned SEL_W  = 4;
  localparam int unsigned CNT_W  = 16;

  // Register write strobes (one-hot)
  localparam logic [WE_W-1:0] WE_PT       = WE_W'(1 << 0);
  localparam logic [WE_W-1:0] WE_IV       = WE_W'(1 << 1);
  localparam logic [WE_W-1:0] WE_AES_CSR  = WE_W'(1 << 3);
  localparam logic [WE_W-1:0] WE_SEED     = WE_W'(1 << 8);
  localparam logic [WE_W-1:0] WE_PRNG_CSR = WE_W'(1 << 10);

  // Read selects
  localparam logic [SEL_W-1:0] SEL_NONE     = SEL_W'(0);
  localparam logic [SEL_W-1:0] SEL_CT       = SEL_W'(2);
  localparam logic [SEL_W-1:0] SEL_AES_CSR  = SEL_W'(3);
  localparam logic [SEL_W-1:0] SEL_GEN      = SEL_W'(5);
  localparam logic [SEL_W-1:0] SEL_PRNG_CSR = SEL_W'(6);

  localparam logic [1:0] OP_PRNG_CONT = 2'b11;
  localparam logic [1:0] ST_BUSY      = 2'b10;
  localparam logic [1:0] ST_DONE      = 2'b01;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_DATA,
    S_WR_IV,
    S_WR_CSR,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_RD_SEL,
    S_RD_CAP,
    S_RESP
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [DATA_W-1:0]   iv_q, iv_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WE_W-1:0]     we_q, we_d;
  logic [DATA_W-1:0]   wbus_q, wbus_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic                rvalid_q, rvalid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                rtimeout_q, rtimeout_d;

  logic [1:0]          status;
  logic                timeout_hit;
  logic                unused_dataout_hi;

  // CSR word: start bit always set; AES carries the decrypt flag, PRNG the load flag
  function automatic logic [DATA_W-1:0] csr_word(input logic [1:0] op);
    logic [DATA_W-1:0] w;
    w    = '0;
    w[2] = 1'b1;
    if (op[1]) w[3] = ~op[0];
    else       w[6] = op[0];
    return w;
  endfunction

  assign status            = dataOut[1:0];
  assign timeout_hit       = (cnt_q >= CNT_LAST);
  assign unused_dataout_hi = ^dataOut[BUS_W-1:DATA_W];

  // State register and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      data_q     <= '0;
      iv_q       <= '0;
      cnt_q      <= '0;
      we_q       <= '0;
      wbus_q     <= '0;
      sel_q      <= '0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rtimeout_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      data_q     <= data_d;
      iv_q       <= iv_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      wbus_q     <= wbus_d;
      sel_q      <= sel_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rtimeout_q <= rtimeout_d;
    end
  end

  // Next-state logic; strobe outputs are decoded from the state being entered
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    data_d     = data_q;
    iv_d       = iv_q;
    cnt_d      = cnt_q;
    we_d       = '0;
    wbus_d     = '0;
    sel_d      = sel_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rtimeout_d = rtimeout_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          data_d  = cmd_data;
          iv_d    = cmd_iv;
          state_d = (cmd_op == OP_PRNG_CONT) ? S_WR_CSR : S_WR_DATA;
        end
      end
      S_WR_DATA: state_d = op_q[1] ? S_WR_CSR : S_WR_IV;
      S_WR_IV:   state_d = S_WR_CSR;
      S_WR_CSR: begin
        cnt_d   = '0;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (status == ST_BUSY) begin
          state_d = S_WAIT_DONE;
        end else if (timeout_hit) begin
          state_d    = S_RESP;
          rvalid_d   = 1'b1;
          rdata_d    = '0;
          rtimeout_d = 1'b1;
        end
      end
      S_WAIT_DONE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (status == ST_DONE) begin
          state_d = S_RD_SEL;
          sel_d   = op_q[1] ? SEL_GEN : SEL_CT;
        end else if (timeout_hit) begin
          state_d    = S_RESP;
          rvalid_d   = 1'b1;
          rdata_d    = '0;
          rtimeout_d = 1'b1;
        end
      end
      S_RD_SEL: state_d = S_RD_CAP;
      S_RD_CAP: begin
        state_d    = S_RESP;
        rvalid_d   = 1'b1;
        rdata_d    = dataOut[DATA_W-1:0];
        rtimeout_d = 1'b0;
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d    = S_IDLE;
          rvalid_d   = 1'b0;
          rdata_d    = '0;
          rtimeout_d = 1'b0;
          sel_d      = SEL_NONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    case (state_d)
      S_WR_DATA: begin
        we_d   = op_d[1] ? WE_SEED : WE_PT;
        wbus_d = data_d;
      end
      S_WR_IV: begin
        we_d   = WE_IV;
        wbus_d = iv_d;
      end
      S_WR_CSR: begin
        we_d   = op_d[1] ? WE_PRNG_CSR : WE_AES_CSR;
        wbus_d = csr_word(op_d);
        sel_d  = op_d[1] ? SEL_PRNG_CSR : SEL_AES_CSR;
      end
      default: ;
    endcase
  end

  assign cmd_ready    = (state_q == S_IDLE);
  assign busy         = (state_q != S_IDLE);
  assign writeEnable  = we_q;
  assign writeBus     = {{(BUS_W-DATA_W){1'b0}}, wbus_q};
  assign selectRead   = sel_q;
  assign resp_valid   = rvalid_q;
  assign resp_data    = rdata_q;
  assign resp_timeout = rtimeout_q;

endmodule

// File: tb/tb_coproc_host_driver.sv
// Bench for coproc_host_driver: behavioural coprocessor model plus a per-job
// expected-result reference and a bus-protocol monitor.
module tb_coproc_host_driver;

  localparam int unsigned TMO = 16;
  localparam logic [127:0] AES_KEY   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KAT_PT    = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] KAT_CT    = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  localparam logic [127:0] PRNG_INIT = 128'h0123456789abcdeffedcba9876543210;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [1:0]   cmd_op = 2'b00;
  logic [127:0] cmd_data = '0;
  logic [127:0] cmd_iv = '0;
  logic         resp_valid;
  logic         resp_ready = 1'b0;
  logic [127:0] resp_data;
  logic         resp_timeout;
  logic         busy;
  logic [15:0]  writeEnable;
  logic [255:0] writeBus;
  logic [3:0]   selectRead;
  logic [255:0] dataOut;

  coproc_host_driver #(.TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .cmd_iv(cmd_iv),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_timeout(resp_timeout), .busy(busy),
    .writeEnable(writeEnable), .writeBus(writeBus),
    .selectRead(selectRead), .dataOut(dataOut)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Stand-in cipher: NIST vector pair under the fixed key, XOR mix otherwise
  function automatic logic [127:0] aes_xform(input logic dec, input logic [127:0] d,
                                             input logic [127:0] iv);
    if (!dec && d == KAT_PT) return KAT_CT;
    if (dec && d == KAT_CT) return KAT_PT;
    return d ^ AES_KEY ^ iv;
  endfunction

  function automatic logic [127:0] prng_step(input logic [127:0] s);
    logic [127:0] x;
    x = s;
    x = x ^ (x << 13);
    x = x ^ (x >> 7);
    x = x ^ (x << 17);
    return x;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Coprocessor model
  logic [127:0] pt_r = '0, iv_r = '0, ct_r = '0, seed_r = '0, gen_r = '0;
  logic [1:0]   aes_stat, prng_stat;
  logic         m_run, m_prng, m_dec, m_load;
  int           m_cnt;
  logic [127:0] m_state = PRNG_INIT;
  int           done_cyc = 0;
  int           m_delay = 0;
  int           m_blen = 1;
  bit           m_never = 1'b0;

  always_comb begin
    dataOut = '0;
    dataOut[255:128] = '1;
    case (selectRead)
      4'd0: dataOut[127:0] = pt_r;
      4'd1: dataOut[127:0] = iv_r;
      4'd2: dataOut[127:0] = ct_r;
      4'd3: dataOut[1:0]   = aes_stat;
      4'd4: dataOut[127:0] = seed_r;
      4'd5: dataOut[127:0] = gen_r;
      4'd6: dataOut[1:0]   = prng_stat;
      default: ;
    endcase
  end

  always @(posedge clock) begin
    if (reset) begin
      m_run     <= 1'b0;
      m_cnt     <= 0;
      aes_stat  <= 2'b01;
      prng_stat <= 2'b01;
    end else begin
      if (writeEnable[0]) pt_r   <= writeBus[127:0];
      if (writeEnable[1]) iv_r   <= writeBus[127:0];
      if (writeEnable[8]) seed_r <= writeBus[127:0];
      if (writeEnable[3] && writeBus[2]) begin
        m_run <= 1'b1; m_prng <= 1'b0; m_dec <= writeBus[6]; m_cnt <= 0;
      end else if (writeEnable[10] && writeBus[2]) begin
        m_run <= 1'b1; m_prng <= 1'b1; m_load <= writeBus[3]; m_cnt <= 0;
      end else if (m_run) begin
        if (m_never) begin
          m_run <= 1'b0;
        end else begin
          m_cnt <= m_cnt + 1;
          if (m_cnt == m_delay) begin
            if (m_prng) prng_stat <= 2'b10;
            else        aes_stat  <= 2'b10;
          end
          if (m_cnt == m_delay + m_blen) begin
            m_run    <= 1'b0;
            done_cyc <= cyc;
            if (m_prng) begin
              prng_stat <= 2'b01;
              gen_r     <= prng_step(m_load ? seed_r : m_state);
              m_state   <= prng_step(m_load ? seed_r : m_state);
            end else begin
              aes_stat <= 2'b01;
              ct_r     <= aes_xform(m_dec, pt_r, iv_r);
            end
          end
        end
      end
    end
  end

  // Bus monitor: logs strobes and counts protocol violations
  logic [15:0]  log_we[$];
  logic [127:0] log_bus[$];
  int           log_cyc[$];
  int           viol = 0;
  int           rv_cycles = 0;

  always @(negedge clock) begin
    if (!reset) begin
      if (writeEnable != '0) begin
        log_we.push_back(writeEnable);
        log_bus.push_back(writeBus[127:0]);
        log_cyc.push_back(cyc);
      end
      if (($countones(writeEnable) > 1) || (writeEnable == '0 && writeBus != '0) ||
          (writeBus[255:128] != '0) || (cmd_ready == busy))
        viol <= viol + 1;
      if (resp_valid) rv_cycles <= rv_cycles + 1;
    end
  end

  logic [127:0] ref_state = PRNG_INIT;

  task automatic run_job(input logic [1:0] op, input logic [127:0] d, input logic [127:0] iv,
                         input int dly, input int bl, input bit never, input int bp);
    logic [127:0] exp;
    logic [15:0]  exp_we[3];
    logic [127:0] exp_bus[3];
    int n_exp, base, acc, resp_cyc, waited, n_got;

    if (never)       exp = '0;
    else if (!op[1]) exp = aes_xform(op[0], d, iv);
    else begin
      ref_state = prng_step(op[0] ? ref_state : d);
      exp = ref_state;
    end
    case (op)
      2'b00, 2'b01: begin
        n_exp = 3;
        exp_we[0] = 16'h0001; exp_bus[0] = d;
        exp_we[1] = 16'h0002; exp_bus[1] = iv;
        exp_we[2] = 16'h0008; exp_bus[2] = op[0] ? 128'h44 : 128'h04;
      end
      2'b10: begin
        n_exp = 2;
        exp_we[0] = 16'h0100; exp_bus[0] = d;
        exp_we[1] = 16'h0400; exp_bus[1] = 128'hC;
      end
      default: begin
        n_exp = 1;
        exp_we[0] = 16'h0400; exp_bus[0] = 128'h4;
      end
    endcase

    m_delay = dly; m_blen = bl; m_never = never;
    waited = 0;
    while (!cmd_ready && waited < 50) begin @(negedge clock); waited++; end
    check_eq("cmd_ready_idle", 256'(cmd_ready), 256'(1'b1));

    base = log_we.size();
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d; cmd_iv = iv;
    @(posedge clock); #1;
    acc = cyc;
    @(negedge clock);
    cmd_valid = 1'b0; cmd_data = rand128(); cmd_iv = rand128();
    check_eq("cmd_ready_busy", 256'(cmd_ready), 256'(1'b0));

    waited = 0;
    while (!resp_valid && waited < 200) begin @(negedge clock); waited++; end
    check_eq("resp_valid_seen", 256'(resp_valid), 256'(1'b1));
    if (!resp_valid) return;
    resp_cyc = cyc;
    check_eq("resp_timeout", 256'(resp_timeout), 256'(never));
    check_eq("resp_data", 256'(resp_data), 256'(exp));
    if (never) check_eq("timeout_latency", 256'(resp_cyc), 256'(acc + n_exp - 1 + 17));
    else       check_eq("done_latency", 256'(resp_cyc), 256'(done_cyc + 4));

    n_got = log_we.size() - base;
    check_eq("strobe_count", 256'(n_got), 256'(n_exp));
    for (int i = 0; i < n_exp && i < n_got; i++) begin
      check_eq("strobe_we", 256'(log_we[base + i]), 256'(exp_we[i]));
      check_eq("strobe_bus", 256'(log_bus[base + i]), 256'(exp_bus[i]));
      check_eq("strobe_cycle", 256'(log_cyc[base + i]), 256'(acc + i));
    end

    for (int i = 0; i < bp; i++) begin
      @(negedge clock);
      check_eq("bp_valid", 256'(resp_valid), 256'(1'b1));
      check_eq("bp_data", 256'(resp_data), 256'(exp));
      check_eq("bp_timeout", 256'(resp_timeout), 256'(never));
    end
    resp_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    resp_ready = 1'b0;
    check_eq("post_valid", 256'(resp_valid), 256'(1'b0));
    check_eq("post_ready", 256'(cmd_ready), 256'(1'b1));
    check_eq("post_sel", 256'(selectRead), 256'(4'd0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got cycle %0d expected < 50000", cyc);
    $fatal(1);
  end

  initial begin
    int snap, waited;
    logic [1:0] op;

    repeat (2) @(negedge clock);
    check_eq("rst_ready", 256'(cmd_ready), 256'(1'b1));
    check_eq("rst_busy", 256'(busy), 256'(1'b0));
    check_eq("rst_valid", 256'(resp_valid), 256'(1'b0));
    check_eq("rst_we", 256'(writeEnable), 256'(16'h0));
    check_eq("rst_sel", 256'(selectRead), 256'(4'h0));
    reset = 1'b0;
    @(negedge clock);

    // Directed: KAT with stale done and late busy, decrypt with backpressure
    run_job(2'b00, KAT_PT, rand128(), 5, 3, 1'b0, 0);
    run_job(2'b01, KAT_CT, rand128(), 0, 2, 1'b0, 10);
    // PRNG seed then continue
    run_job(2'b10, 128'h1, '0, 1, 2, 1'b0, 1);
    run_job(2'b11, rand128(), '0, 2, 1, 1'b0, 0);
    // Timeout: coprocessor never reports busy
    run_job(2'b00, rand128(), rand128(), 0, 1, 1'b1, 2);

    // Reset during WAIT_DONE aborts with no response
    m_delay = 0; m_blen = 6; m_never = 1'b0;
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_data = rand128(); cmd_iv = rand128();
    @(negedge clock);
    cmd_valid = 1'b0;
    waited = 0;
    while (aes_stat != 2'b10 && waited < 50) begin @(negedge clock); waited++; end
    check_eq("rst_job_busy_seen", 256'(aes_stat), 256'(2'b10));
    @(negedge clock);
    snap = rv_cycles;
    reset = 1'b1;
    @(negedge clock);
    check_eq("midrst_we", 256'(writeEnable), 256'(16'h0));
    check_eq("midrst_bus", writeBus, 256'(0));
    check_eq("midrst_sel", 256'(selectRead), 256'(4'h0));
    check_eq("midrst_valid", 256'(resp_valid), 256'(1'b0));
    check_eq("midrst_data", 256'(resp_data), 256'(0));
    check_eq("midrst_tmo", 256'(resp_timeout), 256'(1'b0));
    check_eq("midrst_busy", 256'(busy), 256'(1'b0));
    check_eq("midrst_ready", 256'(cmd_ready), 256'(1'b1));
    reset = 1'b0;
    repeat (20) @(negedge clock);
    check_eq("midrst_no_resp", 256'(rv_cycles - snap), 256'(0));

    // Randomized jobs
    for (int j = 0; j < 16; j++) begin
      op = 2'($urandom_range(0, 3));
      run_job(op, rand128(), rand128(), int'($urandom_range(0, 5)), int'($urandom_range(1, 6)),
              (!op[1]) && ($urandom_range(0, 7) == 0), int'($urandom_range(0, 3)));
    end

    check_eq("protocol_violations", 256'(viol), 256'(0));
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
